uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  - 8N1 asynchronous serial receiver; counterpart to the UART transmitter inside uart_top.
//  - Oversamples ser_in at CLOCKS_PER_BIT clocks per bit and samples each bit at mid-bit.
//  - Outputs each received byte with a one-cycle valid strobe.
//  - Sits beside the transmitter in uart_top; benches loop tx->rx and log rx_data on rx_valid.
// PARAMETERS
//  - CLOCKS_PER_BIT  4  clocks per serial bit; legal range >= 4. Bench uses 4; 12 MHz/115200 uses 104.
// PORTS
//  - clk        in   1  single system clock; all logic on posedge.
//  - rst_n      in   1  asynchronous, active-low reset.
//  - ser_in     in   1  serial line; idle high; asynchronous to clk.
//  - rx_data    out  8  last good byte; holds until the next good byte.
//  - rx_valid   out  1  one-cycle strobe; rx_data is new this cycle.
//  - frame_err  out  1  one-cycle strobe; stop bit sampled low.
//  - rx_busy    out  1  high in every state except IDLE.
// BEHAVIOUR
//  - Reset: all outputs 0; rx_data=8'h00; state IDLE; synchroniser flops=1 (line idle).
//  - Synchroniser: 2-flop ser_in -> s_in. All decisions use s_in, giving 2 cycles of input latency.
//  - Counter: cnt width $clog2(CLOCKS_PER_BIT); bit index width 3.
//  - IDLE: on s_in==0, go to START with cnt=0.
//  - START: count to CLOCKS_PER_BIT/2-1 (integer divide), then resample.
//    - s_in==1: false start; return to IDLE with no strobe.
//    - s_in==0: go to DATA with cnt=0, idx=0.
//  - DATA: sample whenever cnt==CLOCKS_PER_BIT-1, then reset cnt.
//    - Data is LSB first: shift_reg[idx]<=s_in.
//    - After idx==7, go to STOP (or PARITY when the macro is defined).
//  - STOP: sample at cnt==CLOCKS_PER_BIT-1.
//    - s_in==1: next cycle rx_data<=shift_reg, rx_valid=1, state IDLE.
//    - s_in==0: next cycle frame_err=1, rx_data unchanged, state BREAK.
//  - BREAK: wait for s_in==1, then go to IDLE. A held-low line yields exactly one frame_err.
//  - Latency: rx_valid rises 1 clk after the mid-stop-bit sample, i.e. about 9.5 bit times after the start edge, plus 2 sync cycles.
//  - Back-to-back frames: a start edge in the cycle after STOP is accepted. Rx returns to IDLE at mid-stop, so a stop bit shortened by up to half a bit is tolerated.
//  - rx_valid and frame_err are never high together.
//  - rst_n asserted mid-frame: immediate return to reset values; the partial byte is discarded with no strobe.
// CONFIGURATION
//  - UART_RX_PARITY_EN defined:
//    - Adds a PARITY state between DATA and STOP; the frame format becomes 8E1.
//    - Adds output parity_err (out, 1, one-cycle strobe).
//    - Even-parity mismatch (^shift_reg != parity bit): parity_err strobes together with rx_valid, and rx_data still updates.
//  - UART_RX_PARITY_EN undefined:
//    - 8N1 only; no PARITY state; the parity_err port is absent.
// STRUCTURE
//  - Shared package uart_pkg holds:
//    - typedef enum logic[2:0] uart_rx_state_t {IDLE,START,DATA,PARITY,STOP,BREAK};
//    - localparam DATA_BITS=8.
//  - Sub-module uart_sync: 2-flop synchroniser, reset value 1, async active-low reset.
//  - Everything else is one FSM plus counters in uart_rx.
// TESTING (CLOCKS_PER_BIT=4, 12 MHz)
//  - Reset held, ser_in toggling -> all outputs 0, rx_busy 0; after release, state IDLE.
//  - Send 8'h48 ('H') 8N1 -> one rx_valid with rx_data=8'h48, frame_err 0; edge to valid within 40 +/- 2 clocks.
//  - Send 8'h55 then 8'hA3 back-to-back, no idle between -> two rx_valid strobes: 8'h55, then 8'hA3.
//  - Low pulse of 1 clock on idle line -> false start; no strobe; rx_busy drops within 3 clocks.
//  - 8'h3C with stop bit 0, line held low 50 clks -> exactly one frame_err; rx_data keeps previous value; IDLE after line rises.
//  - Assert rst_n at data bit 4 of 8'hFF, release, send 8'h12 -> no strobe for the aborted frame; then rx_data=8'h12.
//  - UART_RX_PARITY_EN: send 8'h07 with parity bit 1 -> rx_valid with rx_data=8'h07, parity_err 0.
//  - UART_RX_PARITY_EN: send 8'h07 with parity bit 0 -> rx_valid and parity_err strobe in the same cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types: receiver state encoding and frame constants.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to 1 (idle line).
module uart_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 oversampling UART receiver, sampling each bit at mid-bit.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity_err strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ser_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       rx_busy
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  logic                 s_in;
  uart_rx_state_t       state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q, perr_d;
  logic                 par_bad_q, par_bad_d;
`endif

  uart_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ser_in),
    .q_o   (s_in)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      IDLE: begin
        if (!s_in) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // Re-check the line half a bit in to reject glitches as false starts.
        if (cnt_q == CNT_HALF) begin
          if (s_in) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          shift_d[idx_q] = s_in;
          cnt_d          = '0;
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          par_bad_d = ((^shift_q) != s_in);
          cnt_d     = '0;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        // Leaving at mid-stop lets a following start edge be caught early.
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (s_in) begin
            state_d = IDLE;
            valid_d = 1'b1;
            data_d  = shift_q;
`ifdef UART_RX_PARITY_EN
            perr_d  = par_bad_q;
`endif
          end else begin
            state_d = BREAK;
            ferr_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        if (s_in) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign frame_err  = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif
  assign rx_busy    = (state_q != IDLE);

endmodule
